seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It shares the single combinational BCD-to-segment decoder (active-low segments, codes 0–9) among all digits. The block holds a double-buffered BCD value, steps through the digits at a programmable rate, drives the active-low anodes, and presents one 4-bit code per slot to the decoder. It sits between the status/counter logic and the display pins.

## Interface
- NUM_DIGITS, 8: number of digits scanned (2–8).
- SCAN_DIV, 100000: clock cycles per digit slot (≥ GHOST_CYC+2).
- GHOST_CYC, 16: anode-off cycles at the start of each slot (anti-ghosting).
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low blanks the display and parks the scan.
- load  in  1  one-cycle strobe; capture load_data into the pending buffer.
- load_data  in  4*NUM_DIGITS  BCD nibbles; nibble i ([4i+3:4i]) is digit i, with digit 0 least significant.
- blank_lead  in  1  enable leading-zero blanking.
- an  out  NUM_DIGITS  anode select, active low, one-hot-low or all ones.
- digit_code  out  4  BCD code to the decoder, always 0–9.
- frame_done  out  1  one-cycle pulse when the shadow buffer is updated.

## Operation
- State: pending[4N], shadow[4N], slot counter cnt (0..SCAN_DIV-1), digit index idx (0..N-1).
- load=1: pending <= load_data. Without a new load, pending holds its value.
- Frame boundary: the cycle where cnt==SCAN_DIV-1 and idx==N-1.
  - At the boundary: shadow <= pending and frame_done pulses.
  - If load coincides with the boundary, shadow takes load_data directly.
- Each cycle with en=1: cnt increments. At SCAN_DIV-1, cnt wraps to 0 and idx advances. idx wraps from N-1 to 0.
- en=0: cnt and idx are forced to 0, an is all ones, and frame_done stays 0. pending still accepts loads. Scanning resumes at digit 0 with cnt=0.
- Digit i is blank if either:
  - its shadow nibble is greater than 9, or
  - blank_lead=1, i≠0, and all shadow nibbles i..N-1 are zero.
  - Digit 0 is never blanked for leading zeros.
- Per slot:
  - an[idx]=0 only when cnt ≥ GHOST_CYC and the digit is not blank. All other an bits are 1.
  - digit_code = shadow nibble idx, or 0 if that nibble is greater than 9. This keeps the decoder in its defined range.

## Timing
- Reset values:
  - an = all ones; digit_code = 0; frame_done = 0.
  - cnt = 0; idx = 0; pending = 0; shadow = 0.
- an and digit_code are registered. The value in cycle k reflects cnt/idx/shadow from cycle k-1, a 1-cycle latency.
- frame_done is registered and is high in the cycle after the boundary. shadow holds the new value in that same cycle.
- Slot length is exactly SCAN_DIV cycles. A frame is N·SCAN_DIV cycles.
- Anodes are lit for SCAN_DIV-GHOST_CYC cycles per slot.
- digit_code changes in the cycle the new slot's first output appears. The anode is off at that point, since the slot starts in the ghost window.
- A load has visible effect at the first frame boundary after it, never mid-frame.
- Reset asserted mid-frame takes effect on the next clk edge. All state returns to reset values and the pending data is lost.
- en deasserted mid-slot: an goes all ones on the next output cycle. No partial-frame shadow update occurs.

## Test plan
Bench parameters: N=4, SCAN_DIV=4, GHOST_CYC=1.
- **Reset:** Hold rst for 3 cycles with en=1. Expect an=4'b1111, digit_code=0, frame_done=0 throughout. After release, with shadow=0, expect an[0] low from output cycle 2 of slot 0. Digits 1–3 are also lit, showing 0, because blank_lead=0.
- **Basic scan:** load_data=16'h1234, then wait one frame. Per slot, expect:
  - digit_code sequence 4,3,2,1;
  - an patterns 1110,1101,1011,0111, each low for 3 of 4 cycles with the first cycle all ones.
- **Leading zero blanking:** load 16'h0050 with blank_lead=1. Expect:
  - digits 3 and 2 with an all ones in their slots;
  - digit 1 lit with code 5;
  - digit 0 lit with code 0.

  Then load 16'h0000: only digit 0 is lit, showing 0.
- **Double buffering and load at boundary:**
  - Load 16'h1111 mid-frame. The frame in progress still shows the old value. frame_done pulses once at its end, then 1s are displayed.
  - Load 16'h2222 exactly at the boundary cycle. The next frame shows 2s immediately.
- **Enable gating:** Drop en in slot 2 cycle 2. Expect an all ones from the next output cycle and no frame_done. Raise en again: the scan restarts at digit 0, with cnt counted from 0.
- **Invalid nibble:** load 16'h00A7. Expect:
  - digit 1 with anode off and digit_code=0;
  - digit 0 showing 7;
  - no code greater than 9 ever appears on digit_code (assert over all cycles).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed common-anode 7-segment display.
// Double-buffered BCD digits, ghost-blanked slots, and leading-zero suppression.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int GHOST_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank_lead,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [3:0]              digit_code,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GHOST = CNT_W'(GHOST_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              nibs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    zero_run;
    logic                    boundary;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nibs[g] = shadow[4*g+3:4*g];
    end

    // Walk from the most significant digit down; zero_run stays set while
    // every digit above and including the current one is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (nibs[i] == 4'd0);
            blank[i] = (nibs[i] > 4'd9) || (blank_lead && (i != 0) && zero_run);
        end
    end

    always_comb begin
        an_next = '1;
        if (en && (cnt >= CNT_GHOST) && !blank[idx]) begin
            an_next[idx] = 1'b0;
        end
    end

    assign boundary = en && (cnt == CNT_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            shadow     <= '0;
            cnt        <= '0;
            idx        <= '0;
            an         <= '1;
            digit_code <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                pending <= load_data;
            end
            // A load landing on the boundary bypasses pending so it is not lost a frame.
            if (boundary) begin
                shadow <= load ? load_data : pending;
            end
            frame_done <= boundary;

            if (!en) begin
                cnt <= '0;
                idx <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            an         <= an_next;
            digit_code <= (nibs[idx] > 4'd9) ? 4'd0 : nibs[idx];
        end
    end

endmodule
